// File: rtl/sram_slot_arbiter.sv
// Shares one async frame SRAM between a display RMW engine (2-cycle read/write pairs)
// and a single-cycle host port; display has priority, host is forced in after STARVE_LIMIT pairs.
module sram_slot_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDISP_REQ,
  input  logic              iDISP_WE,
  input  logic [ADDR_W-1:0] iDISP_ADDR,
  input  logic [DATA_W-1:0] iDISP_WDATA,
  output logic              oDISP_GNT,
  output logic [DATA_W-1:0] oDISP_RDATA,
  output logic              oDISP_RVALID,
  input  logic              iHOST_VALID,
  input  logic              iHOST_WE,
  input  logic [ADDR_W-1:0] iHOST_ADDR,
  input  logic [DATA_W-1:0] iHOST_WDATA,
  output logic              oHOST_READY,
  output logic [DATA_W-1:0] oHOST_RDATA,
  output logic              oHOST_RVALID,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  typedef enum logic [2:0] {
    S_IDLE, S_DISP_RD, S_DISP_WR, S_HOST_RD, S_HOST_WR
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                disp_we_q;
  logic [DATA_W-1:0]   host_wdata_q;
  logic [DATA_W-1:0]   disp_rdata_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                host_rvalid_q;
  logic [7:0]          starve_cnt;
  logic                host_forced;
  logic                dq_oe;
  logic [DATA_W-1:0]   dq_out;

  assign host_forced = iHOST_VALID && (starve_cnt == 8'(STARVE_LIMIT));

  // Every state except DISP_RD is a decision point, so pairs chain back to back.
  always_comb begin
    state_nxt   = S_IDLE;
    oDISP_GNT   = 1'b0;
    oHOST_READY = 1'b0;
    if (state == S_DISP_RD) begin
      state_nxt = S_DISP_WR;
    end else if (host_forced) begin
      oHOST_READY = 1'b1;
      state_nxt   = iHOST_WE ? S_HOST_WR : S_HOST_RD;
    end else if (iDISP_REQ) begin
      oDISP_GNT = 1'b1;
      state_nxt = S_DISP_RD;
    end else if (iHOST_VALID) begin
      oHOST_READY = 1'b1;
      state_nxt   = iHOST_WE ? S_HOST_WR : S_HOST_RD;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      disp_we_q     <= 1'b0;
      host_wdata_q  <= '0;
      disp_rdata_q  <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      starve_cnt    <= 8'd0;
    end else begin
      state         <= state_nxt;
      host_rvalid_q <= (state == S_HOST_RD);
      if (oDISP_GNT) begin
        addr_q    <= iDISP_ADDR;
        disp_we_q <= iDISP_WE;
      end
      if (oHOST_READY) begin
        addr_q       <= iHOST_ADDR;
        host_wdata_q <= iHOST_WDATA;
      end
      if (state == S_DISP_RD) disp_rdata_q <= SRAM_DQ;
      if (state == S_HOST_RD) host_rdata_q <= SRAM_DQ;
      if (oHOST_READY || !iHOST_VALID)
        starve_cnt <= 8'd0;
      else if (oDISP_GNT && starve_cnt != 8'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Strobes come only from the state register, so reset forces them high at once.
  assign oSRAM_CE_N = (state == S_IDLE);
  assign oSRAM_OE_N = !((state == S_DISP_RD) || (state == S_HOST_RD));
  assign dq_oe      = ((state == S_DISP_WR) && disp_we_q) || (state == S_HOST_WR);
  assign oSRAM_WE_N = !dq_oe;
  assign dq_out     = (state == S_HOST_WR) ? host_wdata_q : iDISP_WDATA;
  assign SRAM_DQ    = dq_oe ? dq_out : {DATA_W{1'bz}};

  assign oSRAM_ADDR   = addr_q;
  assign oDISP_RDATA  = disp_rdata_q;
  assign oDISP_RVALID = (state == S_DISP_WR);
  assign oHOST_RDATA  = host_rdata_q;
  assign oHOST_RVALID = host_rvalid_q;

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Owns the single 16-bit async frame SRAM and shares it between the display time-averager and a host port.
- Display side: 2-cycle read-modify-write pair (read old average, write new average) per 2x2 block.
- Host side: single-cycle read or write through a valid/ready handshake, for frame preload, clear and debug readback.
- Sits between the averager datapath and the SRAM pins; has fixed display priority plus host anti-starvation.

Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM data width
- STARVE_LIMIT, 8, consecutive display pairs granted while the host waits before the host is forced in; range 1..255

Ports:
- iCLK  in  1  system clock
- iRST  in  1  asynchronous reset, active-high
- iDISP_REQ  in  1  display requests an RMW pair (level)
- iDISP_WE  in  1  write-back enable for this pair; 0 during blanking
- iDISP_ADDR  in  ADDR_W  pair address
- iDISP_WDATA  in  DATA_W  new average; valid during the DISP_WR cycle
- oDISP_GNT  out  1  pulse: pair accepted
- oDISP_RDATA  out  DATA_W  old average read from SRAM
- oDISP_RVALID  out  1  oDISP_RDATA valid (the DISP_WR cycle)
- iHOST_VALID  in  1  host request valid
- iHOST_WE  in  1  1 = write, 0 = read
- iHOST_ADDR  in  ADDR_W  host address
- iHOST_WDATA  in  DATA_W  host write data
- oHOST_READY  out  1  host request accepted this cycle
- oHOST_RDATA  out  DATA_W  host read data
- oHOST_RVALID  out  1  one-cycle pulse: oHOST_RDATA valid
- oSRAM_ADDR  out  ADDR_W  SRAM address
- oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N  out  1 each  SRAM strobes, active-low
- SRAM_DQ  inout  DATA_W  SRAM data bus

Behaviour:
- States: IDLE, DISP_RD, DISP_WR, HOST_RD, HOST_WR.
- Decision point: any cycle in IDLE, DISP_WR, HOST_RD or HOST_WR. At a decision point:
  - Host forced: iHOST_VALID && starve_cnt == STARVE_LIMIT -> oHOST_READY=1; go to HOST_WR if iHOST_WE, else HOST_RD.
  - Else iDISP_REQ -> oDISP_GNT=1; go to DISP_RD.
  - Else iHOST_VALID -> oHOST_READY=1; go to HOST_WR/HOST_RD.
  - Else -> IDLE.
- oDISP_GNT and oHOST_READY are combinational from the state and the inputs, and are never both 1 in the same cycle.
- Acceptance latches address; display also latches iDISP_WE; host also latches iHOST_WE and iHOST_WDATA.
- Strobes are decoded from the state register only; all three are high in IDLE.
- DISP_RD: CE_N=0, OE_N=0. The DQ value is captured into oDISP_RDATA at the end of the cycle.
- DISP_WR: oDISP_RVALID=1 with the captured data. CE_N=0, OE_N=1. DQ is driven with iDISP_WDATA and WE_N=0 only if the latched iDISP_WE=1; otherwise DQ is hi-Z and WE_N=1.
- HOST_RD: CE_N=0, OE_N=0. DQ is captured at the end of the cycle; oHOST_RVALID pulses for 1 cycle in the following cycle with oHOST_RDATA held until the next host read.
- HOST_WR: CE_N=0, WE_N=0, DQ driven with the latched host data.
- DQ is driven only in DISP_WR (enabled) and HOST_WR; it is hi-Z in every other state.
- Latencies:
  - Display: grant -> read data valid 2 cycles later.
  - Host read: ready -> rvalid 2 cycles later.
  - Back-to-back display pairs sustain 1 pair per 2 cycles.
- starve_cnt (8-bit):
  - Increments on each oDISP_GNT while iHOST_VALID=1.
  - Clears on any oHOST_READY, and whenever iHOST_VALID=0.
  - Saturates at STARVE_LIMIT.
- A preempted display request is not dropped; the requester holds iDISP_REQ until oDISP_GNT.
- Reset (asynchronous, any state):
  - State -> IDLE.
  - CE_N/OE_N/WE_N = 1 immediately; DQ hi-Z.
  - starve_cnt = 0; oDISP_RVALID = oHOST_RVALID = 0; oDISP_RDATA = oHOST_RDATA = 0; oSRAM_ADDR = 0.
  - A write in progress is aborted; no partial strobe is extended.
- Host valid with address/data changing before ready: only the value present at acceptance is used.

Test Plan:
- Reset held while in DISP_WR with WE_N=0 -> WE_N=1 and DQ hi-Z in the same cycle; after release, state is IDLE and all outputs are 0 or high as specified.
- Display request at 0x00123 with SRAM holding 0x1234, iDISP_WDATA=0x2345, iDISP_WE=1 -> GNT at t, OE_N=0 at t+1, RVALID=1 with RDATA 0x1234 at t+2, and 0x2345 written at 0x00123.
- Same pair with iDISP_WE=0 -> read completes, WE_N stays 1, DQ hi-Z, SRAM unchanged.
- Continuous iDISP_REQ plus host write (0x3FFFF, 0xBEEF), STARVE_LIMIT=8 -> exactly 8 display grants, then oHOST_READY; HOST_WR writes 0xBEEF at 0x3FFFF; display resumes on the next decision.
- Idle display, host read of 0x00010 holding 0xA5A5 -> READY at t, OE_N=0 at t+1, RVALID pulse with 0xA5A5 at t+2.
- Random requester traffic against an SRAM model -> no cycle with DQ driven while OE_N=0; GNT and READY never both high; every write lands exactly once.
